// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
//   Drains the UART RX FIFO and turns the ASCII byte stream into single-cycle
//   control pulses and set-time values for the stopwatch/clock core.
//   Single-character commands: R/C/H/M/S (either case). Set-time frame:
//   'T' followed by six decimal digits HHMMSS. CR/LF are ignored silently.
//   A partial T frame is abandoned with cmd_err if no further byte arrives
//   within TIMEOUT_CYCLES clocks.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   fifo_empty     RX FIFO empty flag
//   fifo_rx_data   RX FIFO head byte, valid while fifo_empty is low
//   rd_en          one-cycle pop of the RX FIFO head (combinational)
//   cmd_run_toggle pulse: 'R'/'r' received
//   cmd_clear      pulse: 'C'/'c' received
//   cmd_inc_hour   pulse: 'H'/'h' received
//   cmd_inc_min    pulse: 'M'/'m' received
//   cmd_inc_sec    pulse: 'S'/'s' received
//   set_valid      pulse: valid T frame committed
//   set_hour       committed hour 0-23 (held between commits)
//   set_min        committed minute 0-59 (held between commits)
//   set_sec        committed second 0-59 (held between commits)
//   cmd_err        pulse: unknown byte, bad digit, out-of-range value, timeout
// -----------------------------------------------------------------------------
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    parameter int unsigned TO_W           = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rx_data,
    output logic       rd_en,
    output logic       cmd_run_toggle,
    output logic       cmd_clear,
    output logic       cmd_inc_hour,
    output logic       cmd_inc_min,
    output logic       cmd_inc_sec,
    output logic       set_valid,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       cmd_err
);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_ARG_FETCH = 3'd2,
        ST_ARG_CHECK = 3'd3,
        ST_COMMIT    = 3'd4
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
    localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

    // Map lowercase ASCII letters onto uppercase so the decoder needs one arm.
    function automatic logic [7:0] fold_case(input logic [7:0] b);
        logic [7:0] r;
        if ((b >= 8'h61) && (b <= 8'h7A)) begin
            r = b - 8'h20;
        end else begin
            r = b;
        end
        return r;
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    // tens*10 + ones; 7 bits covers the worst case of 99.
    function automatic logic [6:0] two_digit(input logic [3:0] tens, input logic [3:0] ones);
        return ({3'd0, tens} * 7'd10) + {3'd0, ones};
    endfunction

    state_t            state_r, state_s;
    logic [7:0]        byte_r;
    logic [5:0][3:0]   digit_r;
    logic [2:0]        idx_r, idx_s;
    logic [TO_W-1:0]   to_cnt_r, to_cnt_s;
    logic              digit_we_s;
    logic              rd_en_s;
    logic              run_s, clear_s, inc_hour_s, inc_min_s, inc_sec_s;
    logic              valid_s, err_s;
    logic [6:0]        hh_s, mm_s, ss_s;
    logic              range_ok_s;

    // The pop only happens in a fetch state; the FSM always leaves that state
    // for one cycle afterwards, so a stale head is never popped twice.
    assign rd_en_s = ((state_r == ST_FETCH) || (state_r == ST_ARG_FETCH)) && !fifo_empty;
    assign rd_en   = rd_en_s;

    assign hh_s       = two_digit(digit_r[0], digit_r[1]);
    assign mm_s       = two_digit(digit_r[2], digit_r[3]);
    assign ss_s       = two_digit(digit_r[4], digit_r[5]);
    assign range_ok_s = (hh_s <= 7'd23) && (mm_s <= 7'd59) && (ss_s <= 7'd59);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, next-pulse and datapath-control decode.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        to_cnt_s   = to_cnt_r;
        digit_we_s = 1'b0;
        run_s      = 1'b0;
        clear_s    = 1'b0;
        inc_hour_s = 1'b0;
        inc_min_s  = 1'b0;
        inc_sec_s  = 1'b0;
        valid_s    = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (!fifo_empty) begin
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                state_s = ST_FETCH;
                case (fold_case(byte_r))
                    8'h52:   run_s      = 1'b1;   // 'R'
                    8'h43:   clear_s    = 1'b1;   // 'C'
                    8'h48:   inc_hour_s = 1'b1;   // 'H'
                    8'h4D:   inc_min_s  = 1'b1;   // 'M'
                    8'h53:   inc_sec_s  = 1'b1;   // 'S'
                    8'h54: begin                  // 'T'
                        idx_s    = 3'd0;
                        to_cnt_s = TO_ZERO;
                        state_s  = ST_ARG_FETCH;
                    end
                    8'h0D, 8'h0A: state_s = ST_FETCH;  // CR/LF: line endings from terminals
                    default: err_s = 1'b1;
                endcase
            end
            ST_ARG_FETCH: begin
                // A waiting byte wins over a timeout landing in the same cycle.
                if (!fifo_empty) begin
                    state_s = ST_ARG_CHECK;
                end else if (to_cnt_r == TO_LAST) begin
                    err_s   = 1'b1;
                    state_s = ST_FETCH;
                end else begin
                    to_cnt_s = to_cnt_r + TO_ONE;
                end
            end
            ST_ARG_CHECK: begin
                // A non-digit is consumed here rather than re-decoded as a command.
                if (!is_digit(byte_r)) begin
                    err_s   = 1'b1;
                    state_s = ST_FETCH;
                end else begin
                    digit_we_s = 1'b1;
                    to_cnt_s   = TO_ZERO;
                    if (idx_r == 3'd5) begin
                        state_s = ST_COMMIT;
                    end else begin
                        idx_s   = idx_r + 3'd1;
                        state_s = ST_ARG_FETCH;
                    end
                end
            end
            ST_COMMIT: begin
                if (range_ok_s) begin
                    valid_s = 1'b1;
                end else begin
                    err_s = 1'b1;
                end
                state_s = ST_FETCH;
            end
            default: state_s = ST_FETCH;
        endcase
    end

    // Byte latch, digit buffer, digit index and inter-byte timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_r   <= 8'h00;
            digit_r  <= {24{1'b0}};
            idx_r    <= 3'd0;
            to_cnt_r <= TO_ZERO;
        end else begin
            if (rd_en_s) begin
                byte_r <= fifo_rx_data;
            end
            if (digit_we_s) begin
                // For '0'-'9' the low nibble equals byte - 0x30.
                digit_r[idx_r] <= byte_r[3:0];
            end
            idx_r    <= idx_s;
            to_cnt_r <= to_cnt_s;
        end
    end

    // Registered pulse outputs and held set-time values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_run_toggle <= 1'b0;
            cmd_clear      <= 1'b0;
            cmd_inc_hour   <= 1'b0;
            cmd_inc_min    <= 1'b0;
            cmd_inc_sec    <= 1'b0;
            set_valid      <= 1'b0;
            cmd_err        <= 1'b0;
            set_hour       <= 5'd0;
            set_min        <= 6'd0;
            set_sec        <= 6'd0;
        end else begin
            cmd_run_toggle <= run_s;
            cmd_clear      <= clear_s;
            cmd_inc_hour   <= inc_hour_s;
            cmd_inc_min    <= inc_min_s;
            cmd_inc_sec    <= inc_sec_s;
            set_valid      <= valid_s;
            cmd_err        <= err_s;
            if (valid_s) begin
                set_hour <= hh_s[4:0];
                set_min  <= mm_s[5:0];
                set_sec  <= ss_s[5:0];
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_ctrl
//   Directed bench for uart_cmd_ctrl. A queue models the RX FIFO. Every cycle
//   the monitor logs rd_en pops and output pulses (as letters R,C,H,M,S,V,E)
//   with their cycle numbers. A table of byte strings with hand-computed
//   expected pop counts, pulse sequences and set-time values is applied in a
//   loop; hand-written sequences cover latency, timeout and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rx_data = 8'h00;
    logic       rd_en;
    logic       cmd_run_toggle, cmd_clear, cmd_inc_hour, cmd_inc_min, cmd_inc_sec;
    logic       set_valid, cmd_err;
    logic [4:0] set_hour;
    logic [5:0] set_min, set_sec;

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_empty     (fifo_empty),
        .fifo_rx_data   (fifo_rx_data),
        .rd_en          (rd_en),
        .cmd_run_toggle (cmd_run_toggle),
        .cmd_clear      (cmd_clear),
        .cmd_inc_hour   (cmd_inc_hour),
        .cmd_inc_min    (cmd_inc_min),
        .cmd_inc_sec    (cmd_inc_sec),
        .set_valid      (set_valid),
        .set_hour       (set_hour),
        .set_min        (set_min),
        .set_sec        (set_sec),
        .cmd_err        (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        string stim;
        int    rd;
        string ev;
        int    h;
        int    m;
        int    s;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] fq[$];
    int         rdcyc[$];
    int         evcyc[$];
    string      ev_log = "";
    int         cyc = 0;
    int         rd_cnt = 0;
    int         multi_cnt = 0;
    bit         pop_req = 1'b0;
    int         n_vec = 0;
    int         n_fail = 0;

    task automatic refresh();
        fifo_empty   = (fq.size() == 0);
        fifo_rx_data = (fq.size() == 0) ? 8'h00 : fq[0];
    endtask

    task automatic note(input string c);
        ev_log = {ev_log, c};
        evcyc.push_back(cyc);
    endtask

    // Monitor: sample between edges, log pops and pulses.
    always @(negedge clk) begin
        #3;
        cyc = cyc + 1;
        pop_req = (rd_en === 1'b1);
        if (pop_req) begin
            rd_cnt = rd_cnt + 1;
            rdcyc.push_back(cyc);
        end
        if ($countones({cmd_run_toggle, cmd_clear, cmd_inc_hour, cmd_inc_min,
                        cmd_inc_sec, set_valid, cmd_err}) > 1) multi_cnt = multi_cnt + 1;
        if (cmd_run_toggle === 1'b1) note("R");
        if (cmd_clear === 1'b1)      note("C");
        if (cmd_inc_hour === 1'b1)   note("H");
        if (cmd_inc_min === 1'b1)    note("M");
        if (cmd_inc_sec === 1'b1)    note("S");
        if (set_valid === 1'b1)      note("V");
        if (cmd_err === 1'b1)        note("E");
    end

    // FIFO model: pop just after the edge on which rd_en was seen high.
    always @(posedge clk) begin
        #1;
        if (pop_req && (fq.size() > 0)) void'(fq.pop_front());
        pop_req = 1'b0;
        refresh();
    end

    task automatic check_int(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic check_str(input string nm, input string got, input string exp);
        n_vec = n_vec + 1;
        if (got != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got \"%s\", expected \"%s\"", nm, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #4;
    endtask

    task automatic push_str(input string s);
        @(negedge clk);
        #1;
        for (int i = 0; i < s.len(); i++) fq.push_back(s[i]);
        refresh();
    endtask

    task automatic clear_log();
        ev_log = "";
        evcyc.delete();
        rdcyc.delete();
        rd_cnt = 0;
    endtask

    task automatic check_set(input string nm, input int h, input int m, input int s);
        check_int({nm, " set_hour"}, 32'(set_hour), h);
        check_int({nm, " set_min"},  32'(set_min),  m);
        check_int({nm, " set_sec"},  32'(set_sec),  s);
    endtask

    task automatic add_vec(input string name, input string stim, input int rd,
                           input string ev, input int h, input int m, input int s);
        vec_t v;
        v.name = name; v.stim = stim; v.rd = rd; v.ev = ev;
        v.h = h; v.m = m; v.s = s;
        vq.push_back(v);
    endtask

    initial begin
        int d;

        // name, bytes, pops, pulse sequence, set_hour/min/sec afterwards
        add_vec("clear",      "C",             1, "C",    0,  0,  0);
        add_vec("hms",        "HmS",           3, "HMS",  0,  0,  0);
        add_vec("set_max",    "T235959",       7, "V",   23, 59, 59);
        add_vec("hour_24",    "T240000",       7, "E",   23, 59, 59);
        add_vec("bad_digit",  "T12a",          4, "E",   23, 59, 59);
        add_vec("resync",     "s",             1, "S",   23, 59, 59);
        add_vec("crlf_x",     "\015\012x",     3, "E",   23, 59, 59);
        add_vec("lower_t",    "t070809",       7, "V",    7,  8,  9);
        add_vec("sec_60",     "T000060",       7, "E",    7,  8,  9);
        add_vec("min_60",     "T006000",       7, "E",    7,  8,  9);
        add_vec("colon",      "T1:",           3, "E",    7,  8,  9);
        add_vec("slash",      "T/",            2, "E",    7,  8,  9);
        add_vec("mix",        "cRrZ",          4, "CRRE", 7,  8,  9);
        add_vec("zeros",      "T000000",       7, "V",    0,  0,  0);
        add_vec("hour_23",    "T230000",       7, "V",   23,  0,  0);
        add_vec("cmd_frame",  "hT235900M",     9, "HVM", 23, 59,  0);

        // Reset state
        wait_cyc(4);
        @(negedge clk);
        #1 reset = 1'b0;
        clear_log();
        wait_cyc(5);
        check_int("reset rd_en", 32'(rd_en), 0);
        check_int("reset pops", rd_cnt, 0);
        check_str("reset pulses", ev_log, "");
        check_set("reset", 0, 0, 0);

        // Table-driven vectors
        for (int i = 0; i < vq.size(); i++) begin
            clear_log();
            push_str(vq[i].stim);
            wait_cyc(40);
            check_int({vq[i].name, " pops"}, rd_cnt, vq[i].rd);
            check_str({vq[i].name, " pulses"}, ev_log, vq[i].ev);
            check_set(vq[i].name, vq[i].h, vq[i].m, vq[i].s);
            check_int({vq[i].name, " fifo_empty"}, 32'(fifo_empty), 1);
        end

        // Command latency: pulse two cycles after the pop
        clear_log();
        push_str("C");
        wait_cyc(20);
        check_str("lat_c pulses", ev_log, "C");
        d = ((evcyc.size() > 0) && (rdcyc.size() > 0)) ? (evcyc[0] - rdcyc[$]) : -1;
        check_int("lat_c delay", d, 2);

        // Frame latency: set_valid three cycles after the last digit pop
        clear_log();
        push_str("T000001");
        wait_cyc(30);
        check_str("lat_t pulses", ev_log, "V");
        d = ((evcyc.size() > 0) && (rdcyc.size() > 0)) ? (evcyc[0] - rdcyc[$]) : -1;
        check_int("lat_t delay", d, 3);
        check_set("lat_t", 0, 0, 1);

        // Timeout: wait entered two cycles after the '2' pop, error 50 later
        clear_log();
        push_str("T12");
        wait_cyc(80);
        check_int("timeout pops", rd_cnt, 3);
        check_str("timeout pulses", ev_log, "E");
        d = ((evcyc.size() > 0) && (rdcyc.size() > 0)) ? (evcyc[0] - rdcyc[$]) : -1;
        check_int("timeout delay", d, 2 + TO);
        clear_log();
        push_str("T000005");
        wait_cyc(30);
        check_str("after_to pulses", ev_log, "V");
        check_set("after_to", 0, 0, 5);

        // Slow frame: 30-cycle gaps stay inside the timeout window
        clear_log();
        push_str("T");
        wait_cyc(30);
        for (int i = 0; i < 6; i++) begin
            string dg;
            dg = $sformatf("%0d", i + 1);
            push_str(dg);
            wait_cyc(30);
        end
        check_str("slow pulses", ev_log, "V");
        check_set("slow", 12, 34, 56);

        // Reset after three digits of a frame
        clear_log();
        push_str("T123");
        wait_cyc(12);
        check_str("pre_rst pulses", ev_log, "");
        @(negedge clk);
        #1 reset = 1'b1;
        wait_cyc(3);
        @(negedge clk);
        #1 reset = 1'b0;
        wait_cyc(TO + 10);
        check_str("mid_rst pulses", ev_log, "");
        check_set("mid_rst", 0, 0, 0);
        clear_log();
        push_str("R");
        wait_cyc(20);
        check_str("post_rst pulses", ev_log, "R");
        check_int("post_rst pops", rd_cnt, 1);

        check_int("onehot violations", multi_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
